pw_conv_1x1_rq: RTL and testbench
=================================

Name: pw_conv_1x1_rq

Overview:
Vectorised 1x1 pointwise convolution engine with a pipelined MAC and per-output-channel int8 requantisation. Each input beat carries IC_PAR input channels. The block accumulates OC_PAR output channels over a run of beats delimited by first_in_ch and last_in_ch. On the last beat it requantises the accumulators (fixed-point multiply, rounding shift, zero-point add, clamp) and pushes the result into an internal output FIFO. It sits between the line-buffer/weight-fetch front end and the feature-map writer in the MobileNet-style datapath.

Parameters:
DATA_W, 8, input activation/weight width (signed)
ACC_W, 32, accumulator and bias width (signed)
OC_PAR, 16, output channels computed in parallel
IC_PAR, 8, input channels consumed per beat
MULT_W, 32, requant multiplier width (signed Q0.31)
SHIFT_W, 5, requant extra right-shift width (unsigned, 0..31)
OUT_W, 8, requantised output width (signed)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&&in_ready
in_data_vec  in  IC_PAR*DATA_W  activations, lane j at [j*DATA_W +: DATA_W]
weight_vec  in  OC_PAR*IC_PAR*DATA_W  weight (i,j) at [(i*IC_PAR+j)*DATA_W +: DATA_W]
bias_vec  in  OC_PAR*ACC_W  per-OC bias, used on first beat only
first_in_ch  in  1  beat starts a new accumulation
last_in_ch  in  1  beat ends the accumulation
rq_mult_vec  in  OC_PAR*MULT_W  per-OC multiplier, sampled on last beat
rq_shift_vec  in  OC_PAR*SHIFT_W  per-OC shift, sampled on last beat
out_zp  in  OUT_W  output zero point, sampled on last beat
act_min  in  OUT_W  clamp low, sampled on last beat
act_max  in  OUT_W  clamp high, sampled on last beat
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_data_vec  out  OC_PAR*OUT_W  requantised outputs, OC i at [i*OUT_W +: OUT_W]
out_acc_vec  out  OC_PAR*ACC_W  raw pre-requant accumulators for the head entry
busy  out  1  any pipeline stage or FIFO entry occupied

Behaviour:
- Reset: all pipeline valids, acc_reg, FIFO pointers/count cleared; out_valid=0, out_data_vec=0, out_acc_vec=0, busy=0, in_ready=1 after reset deasserts. Reset mid-operation discards all partial sums and FIFO contents.
- Pipeline never stalls. S1 registers the per-OC sum of IC_PAR sign-extended products, plus first/last flags, bias (if first) and requant params (if last). S2 adds the S1 sum to base = first ? bias : acc_reg. If the beat is last, the total goes to S3 and acc_reg clears to 0; otherwise acc_reg takes the total. S3 requantises and writes the FIFO.
- Latency: last beat accepted at cycle T -> out_valid at T+3 if FIFO was empty.
- Credit: occ = FIFO count + number of S1/S2/S3 stages holding a last beat. in_ready = (occ < FIFO_DEPTH), registered-free and independent of out_ready/last_in_ch. The FIFO can never overflow.
- first&&last on the same beat: bias + one beat of products, output produced.
- Beat without first after a completed group: base is 0 (acc_reg cleared).
- Requant per OC: p = acc * mult (ACC_W+MULT_W signed); s = 31+shift; r = (p + 2^(s-1)) >>> s (round half toward +inf); y = r + zp at full width; y = min(y, act_max), then max(y, act_min). If act_min>act_max, the result is act_min.
- All products and sums are in ACC_W two's complement with wrap, no saturation.
- FIFO: out_data_vec/out_acc_vec show the head; a pop occurs on out_valid&&out_ready. Simultaneous push and pop in the same cycle is legal at any count, including full; count stays the same.
- busy = any stage valid || FIFO count != 0.

Test Plan:
- Single beat first=last, x all 1, w all 2, bias 10, mult 2^30, shift 0, zp 0, clamp [-128,127] -> acc 26, out 13 on all OCs, out_valid at T+3.
- Three beats (first, mid, last), x=1, w=1, bias 0, mult 2^30 -> acc 24, out 12. A following group without a first beat starts from 0.
- Rounding: acc 27 -> out 14. Acc -27 -> out -13. Shift 1, acc 27 -> out 7. zp 5 adds 5.
- Clamp: act_min 0, act_max 6 (ReLU6): acc 40 -> out 6, acc -10 -> out 0, acc 20 with mult 2^30 -> out 6.
- Backpressure: out_ready=0, stream 6 single-beat groups -> in_ready drops after 4 accepts, no loss. Release out_ready -> 6 outputs in order, values intact.
- Reset asserted with 2 FIFO entries and an open accumulation -> out_valid=0, busy=0 immediately. The next group gives a clean result with no residue.

Source files
------------

// File: rtl/pw_conv_1x1_rq.sv
// 1x1 pointwise convolution: IC_PAR-wide MAC over OC_PAR output channels with
// per-channel int8 requantisation into a small output FIFO guarded by credits.
module pw_conv_1x1_rq #(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 32,
  parameter int OC_PAR     = 16,
  parameter int IC_PAR     = 8,
  parameter int MULT_W     = 32,
  parameter int SHIFT_W    = 5,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IC_PAR*DATA_W-1:0]         in_data_vec,
  input  logic [OC_PAR*IC_PAR*DATA_W-1:0]  weight_vec,
  input  logic [OC_PAR*ACC_W-1:0]          bias_vec,
  input  logic                             first_in_ch,
  input  logic                             last_in_ch,
  input  logic [OC_PAR*MULT_W-1:0]         rq_mult_vec,
  input  logic [OC_PAR*SHIFT_W-1:0]        rq_shift_vec,
  input  logic [OUT_W-1:0]                 out_zp,
  input  logic [OUT_W-1:0]                 act_min,
  input  logic [OUT_W-1:0]                 act_max,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OC_PAR*OUT_W-1:0]          out_data_vec,
  output logic [OC_PAR*ACC_W-1:0]          out_acc_vec,
  output logic                             busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PROD_W = ACC_W + MULT_W;
  localparam int SH_W   = (SHIFT_W > 5) ? SHIFT_W + 1 : 7;

  // Handshake: a transfer happens on a cycle where valid && ready are both high;
  // in_ready depends only on internal occupancy, never on in_valid or out_ready.
  logic in_fire;
  logic pop;
  logic push;

  logic                       s1_valid, s1_first, s1_last;
  logic [OC_PAR*MULT_W-1:0]   s1_mult, s2_mult;
  logic [OC_PAR*SHIFT_W-1:0]  s1_shift, s2_shift;
  logic [OUT_W-1:0]           s1_zp, s1_min, s1_max;
  logic [OUT_W-1:0]           s2_zp, s2_min, s2_max;
  logic                       s2_valid;
  logic [OC_PAR*ACC_W-1:0]    s2_acc_vec;
  logic [OC_PAR*OUT_W-1:0]    rq_vec;

  logic [OC_PAR*OUT_W-1:0]    fifo_data [FIFO_DEPTH];
  logic [OC_PAR*ACC_W-1:0]    fifo_acc  [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic [CNT_W-1:0]           count;
  logic [CNT_W+1:0]           occ;

  assign in_fire = in_valid && in_ready;
  assign push    = s2_valid;
  assign pop     = out_valid && out_ready;

  // Every last beat in flight holds a reserved FIFO slot, so pushes never overflow.
  assign occ      = (CNT_W+2)'(count) + (CNT_W+2)'(s1_valid && s1_last) + (CNT_W+2)'(s2_valid);
  assign in_ready = occ < (CNT_W+2)'(FIFO_DEPTH);
  assign busy     = s1_valid || s2_valid || (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_mult  <= '0;
      s1_shift <= '0;
      s1_zp    <= '0;
      s1_min   <= '0;
      s1_max   <= '0;
      s2_valid <= 1'b0;
      s2_mult  <= '0;
      s2_shift <= '0;
      s2_zp    <= '0;
      s2_min   <= '0;
      s2_max   <= '0;
    end else begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_first <= first_in_ch;
        s1_last  <= last_in_ch;
        if (last_in_ch) begin
          s1_mult  <= rq_mult_vec;
          s1_shift <= rq_shift_vec;
          s1_zp    <= out_zp;
          s1_min   <= act_min;
          s1_max   <= act_max;
        end
      end
      s2_valid <= s1_valid && s1_last;
      if (s1_valid && s1_last) begin
        s2_mult  <= s1_mult;
        s2_shift <= s1_shift;
        s2_zp    <= s1_zp;
        s2_min   <= s1_min;
        s2_max   <= s1_max;
      end
    end
  end

  for (genvar g = 0; g < OC_PAR; g++) begin : g_oc
    logic signed [ACC_W-1:0]  mac_sum, s1_sum, s1_bias, acc_reg, base, total, s2_acc;
    logic signed [MULT_W-1:0] mult;
    logic signed [PROD_W-1:0] prod;
    logic [SH_W-1:0]          sh;
    logic signed [PROD_W:0]   rnd_add, rounded, y, hi, lo, y_hi, y_lo;

    always_comb begin
      mac_sum = '0;
      for (int j = 0; j < IC_PAR; j++) begin
        mac_sum = mac_sum + ACC_W'($signed(in_data_vec[j*DATA_W +: DATA_W]) *
                                   $signed(weight_vec[(g*IC_PAR+j)*DATA_W +: DATA_W]));
      end
    end

    assign base  = s1_first ? s1_bias : acc_reg;
    assign total = s1_sum + base;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_sum  <= '0;
        s1_bias <= '0;
        acc_reg <= '0;
        s2_acc  <= '0;
      end else begin
        if (in_fire) begin
          s1_sum <= mac_sum;
          if (first_in_ch) s1_bias <= $signed(bias_vec[g*ACC_W +: ACC_W]);
        end
        if (s1_valid) begin
          if (s1_last) begin
            acc_reg <= '0;
            s2_acc  <= total;
          end else begin
            acc_reg <= total;
          end
        end
      end
    end

    // Requant: round-half-up shift by 31+shift, add zero point, clamp max then min.
    assign mult    = $signed(s2_mult[g*MULT_W +: MULT_W]);
    assign prod    = PROD_W'(s2_acc) * PROD_W'(mult);
    assign sh      = SH_W'(31) + SH_W'(s2_shift[g*SHIFT_W +: SHIFT_W]);
    assign rnd_add = (PROD_W+1)'(prod) + $signed({{PROD_W{1'b0}}, 1'b1} << (sh - SH_W'(1)));
    assign rounded = rnd_add >>> sh;
    assign y       = rounded + (PROD_W+1)'($signed(s2_zp));
    assign hi      = (PROD_W+1)'($signed(s2_max));
    assign lo      = (PROD_W+1)'($signed(s2_min));
    assign y_hi    = (y > hi) ? hi : y;
    assign y_lo    = (y_hi < lo) ? lo : y_hi;

    assign rq_vec[g*OUT_W +: OUT_W]     = y_lo[OUT_W-1:0];
    assign s2_acc_vec[g*ACC_W +: ACC_W] = s2_acc;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= rq_vec;
      fifo_acc[wr_ptr]  <= s2_acc_vec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_valid    = (count != '0);
  assign out_data_vec = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_acc_vec  = out_valid ? fifo_acc[rd_ptr]  : '0;

endmodule

// File: tb/tb_pw_conv_1x1_rq.sv
// Bench for pw_conv_1x1_rq: directed and random beats checked against an
// integer reference model of the convolution and requantisation.
module tb_pw_conv_1x1_rq;
  localparam int DATA_W = 8, ACC_W = 32, OC_PAR = 16, IC_PAR = 8;
  localparam int MULT_W = 32, SHIFT_W = 5, OUT_W = 8, FIFO_DEPTH = 4;
  localparam int DV_W = OC_PAR*OUT_W;
  localparam int AV_W = OC_PAR*ACC_W;
  localparam int Q30 = 1073741824;

  logic                            clk, rst_n;
  logic                            in_valid, in_ready;
  logic [IC_PAR*DATA_W-1:0]        in_data_vec;
  logic [OC_PAR*IC_PAR*DATA_W-1:0] weight_vec;
  logic [OC_PAR*ACC_W-1:0]         bias_vec;
  logic                            first_in_ch, last_in_ch;
  logic [OC_PAR*MULT_W-1:0]        rq_mult_vec;
  logic [OC_PAR*SHIFT_W-1:0]       rq_shift_vec;
  logic [OUT_W-1:0]                out_zp, act_min, act_max;
  logic                            out_valid, out_ready;
  logic [DV_W-1:0]                 out_data_vec;
  logic [AV_W-1:0]                 out_acc_vec;
  logic                            busy;

  pw_conv_1x1_rq #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .OC_PAR(OC_PAR), .IC_PAR(IC_PAR),
    .MULT_W(MULT_W), .SHIFT_W(SHIFT_W), .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data_vec(in_data_vec), .weight_vec(weight_vec), .bias_vec(bias_vec),
    .first_in_ch(first_in_ch), .last_in_ch(last_in_ch),
    .rq_mult_vec(rq_mult_vec), .rq_shift_vec(rq_shift_vec), .out_zp(out_zp),
    .act_min(act_min), .act_max(act_max), .out_valid(out_valid),
    .out_ready(out_ready), .out_data_vec(out_data_vec),
    .out_acc_vec(out_acc_vec), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int x_m[IC_PAR];
  int w_m[OC_PAR][IC_PAR];
  int bias_m[OC_PAR], mult_m[OC_PAR], shift_m[OC_PAR];
  int zp_m, min_m, max_m;
  int m_acc[OC_PAR];

  logic [DV_W-1:0] exp_q[$];
  logic [AV_W-1:0] exp_acc_q[$];
  int checks, errors, accept_cnt, pop_cnt;
  bit rand_ready;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] ref_rq(input int acc, input int mult, input int shift);
    longint p, r, y, one;
    int s;
    logic [OUT_W-1:0] res;
    one = 1;
    p = longint'(acc) * longint'(mult);
    s = 31 + shift;
    r = (p + (one <<< (s - 1))) >>> s;
    y = r + zp_m;
    if (y > max_m) y = max_m;
    if (y < min_m) y = min_m;
    res = y[OUT_W-1:0];
    return res;
  endfunction

  task automatic model_beat();
    logic [DV_W-1:0] dv;
    logic [AV_W-1:0] av;
    int sum, tot;
    dv = '0;
    av = '0;
    for (int i = 0; i < OC_PAR; i++) begin
      sum = 0;
      for (int j = 0; j < IC_PAR; j++) sum += x_m[j] * w_m[i][j];
      tot = (first_in_ch ? bias_m[i] : m_acc[i]) + sum;
      if (last_in_ch) begin
        av[i*ACC_W +: ACC_W] = tot;
        dv[i*OUT_W +: OUT_W] = ref_rq(tot, mult_m[i], shift_m[i]);
        m_acc[i] = 0;
      end else begin
        m_acc[i] = tot;
      end
    end
    if (last_in_ch) begin
      exp_q.push_back(dv);
      exp_acc_q.push_back(av);
    end
  endtask

  // One clock: scoreboard the pop and model the accept that this edge will perform.
  task automatic tick();
    logic have;
    if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
    if (out_valid && out_ready) begin
      pop_cnt++;
      have = (exp_q.size() != 0);
      chk("pop_expected", 512'(have), 512'(1'b1));
      if (have) begin
        chk("pop_data", 512'(out_data_vec), 512'(exp_q.pop_front()));
        chk("pop_acc", 512'(out_acc_vec), 512'(exp_acc_q.pop_front()));
      end
    end
    if (in_valid && in_ready) begin
      accept_cnt++;
      model_beat();
    end
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic apply();
    for (int j = 0; j < IC_PAR; j++) in_data_vec[j*DATA_W +: DATA_W] = DATA_W'(x_m[j]);
    for (int i = 0; i < OC_PAR; i++) begin
      for (int j = 0; j < IC_PAR; j++)
        weight_vec[(i*IC_PAR+j)*DATA_W +: DATA_W] = DATA_W'(w_m[i][j]);
      bias_vec[i*ACC_W +: ACC_W]         = ACC_W'(bias_m[i]);
      rq_mult_vec[i*MULT_W +: MULT_W]    = MULT_W'(mult_m[i]);
      rq_shift_vec[i*SHIFT_W +: SHIFT_W] = SHIFT_W'(shift_m[i]);
    end
    out_zp  = OUT_W'(zp_m);
    act_min = OUT_W'(min_m);
    act_max = OUT_W'(max_m);
  endtask

  task automatic set_uniform(input int x, input int w, input int b, input int mult,
                             input int shift, input int zp, input int mn, input int mx);
    for (int j = 0; j < IC_PAR; j++) x_m[j] = x;
    for (int i = 0; i < OC_PAR; i++) begin
      for (int j = 0; j < IC_PAR; j++) w_m[i][j] = w;
      bias_m[i]  = b;
      mult_m[i]  = mult;
      shift_m[i] = shift;
    end
    zp_m = zp; min_m = mn; max_m = mx;
    apply();
  endtask

  task automatic set_random();
    int t;
    for (int j = 0; j < IC_PAR; j++) x_m[j] = $urandom_range(0, 255) - 128;
    for (int i = 0; i < OC_PAR; i++) begin
      for (int j = 0; j < IC_PAR; j++) w_m[i][j] = $urandom_range(0, 255) - 128;
      bias_m[i]  = int'($urandom());
      mult_m[i]  = int'($urandom());
      shift_m[i] = $urandom_range(0, 31);
    end
    zp_m  = $urandom_range(0, 255) - 128;
    min_m = $urandom_range(0, 127) - 128;
    max_m = $urandom_range(0, 127);
    if ($urandom_range(0, 7) == 0) begin
      t = min_m; min_m = max_m; max_m = t;
    end
    apply();
  endtask

  task automatic send(input logic first, input logic last);
    int n;
    first_in_ch = first;
    last_in_ch  = last;
    in_valid    = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 512'(in_ready), 512'(1'b1));
    else tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      tick();
      n++;
    end
    chk("drain_queue_empty", 512'(exp_q.size()), 512'(0));
    chk("drain_idle", 512'(busy), 512'(1'b0));
  endtask

  // Last beat with empty FIFO: out_valid must rise exactly three cycles after acceptance.
  task automatic check_last(input string tag, input logic first, input int exp_out, input int exp_acc);
    logic [OUT_W-1:0] eo;
    logic [ACC_W-1:0] ea;
    eo = exp_out;
    ea = exp_acc;
    out_ready = 1'b0;
    send(first, 1'b1);
    chk({tag, "_lat1"}, 512'(out_valid), 512'(1'b0));
    tick();
    chk({tag, "_lat2"}, 512'(out_valid), 512'(1'b0));
    tick();
    chk({tag, "_lat3"}, 512'(out_valid), 512'(1'b1));
    chk({tag, "_out0"}, 512'(out_data_vec[OUT_W-1:0]), 512'(eo));
    chk({tag, "_outN"}, 512'(out_data_vec[DV_W-1 -: OUT_W]), 512'(eo));
    chk({tag, "_acc0"}, 512'(out_acc_vec[ACC_W-1:0]), 512'(ea));
    drain();
  endtask

  initial begin
    int base_acc, base_pop, prev, n;
    checks = 0; errors = 0; accept_cnt = 0; pop_cnt = 0;
    rand_ready = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    first_in_ch = 1'b0; last_in_ch = 1'b0;
    for (int i = 0; i < OC_PAR; i++) m_acc[i] = 0;
    set_uniform(0, 0, 0, 0, 0, 0, -128, 127);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    chk("rst_out_valid", 512'(out_valid), 512'(1'b0));
    chk("rst_out_data", 512'(out_data_vec), 512'(0));
    chk("rst_out_acc", 512'(out_acc_vec), 512'(0));
    chk("rst_busy", 512'(busy), 512'(1'b0));
    chk("rst_in_ready", 512'(in_ready), 512'(1'b1));

    set_uniform(1, 2, 10, Q30, 0, 0, -128, 127);
    check_last("single", 1'b1, 13, 26);

    set_uniform(1, 1, 0, Q30, 0, 0, -128, 127);
    out_ready = 1'b0;
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    check_last("three_beat", 1'b0, 12, 24);
    check_last("no_first", 1'b0, 4, 8);

    set_uniform(0, 0, 27, Q30, 0, 0, -128, 127);
    check_last("round_pos", 1'b1, 14, 27);
    set_uniform(0, 0, -27, Q30, 0, 0, -128, 127);
    check_last("round_neg", 1'b1, -13, -27);
    set_uniform(0, 0, 27, Q30, 1, 0, -128, 127);
    check_last("round_shift1", 1'b1, 7, 27);
    set_uniform(0, 0, 27, Q30, 0, 5, -128, 127);
    check_last("zero_point", 1'b1, 19, 27);

    set_uniform(0, 0, 40, Q30, 0, 0, 0, 6);
    check_last("relu6_hi", 1'b1, 6, 40);
    set_uniform(0, 0, -10, Q30, 0, 0, 0, 6);
    check_last("relu6_lo", 1'b1, 0, -10);
    set_uniform(0, 0, 20, Q30, 0, 0, 0, 6);
    check_last("relu6_mid", 1'b1, 6, 20);
    set_uniform(0, 0, 20, Q30, 0, 0, 9, 3);
    check_last("min_gt_max", 1'b1, 9, 20);

    // Backpressure: FIFO credits admit exactly FIFO_DEPTH groups.
    base_acc = accept_cnt;
    base_pop = pop_cnt;
    set_random();
    out_ready = 1'b0;
    first_in_ch = 1'b1; last_in_ch = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      prev = accept_cnt;
      tick();
      if (accept_cnt != prev) set_random();
    end
    chk("bp_accepts", 512'(accept_cnt - base_acc), 512'(FIFO_DEPTH));
    chk("bp_in_ready_low", 512'(in_ready), 512'(1'b0));
    chk("bp_out_valid", 512'(out_valid), 512'(1'b1));
    out_ready = 1'b1;
    n = 0;
    while (accept_cnt - base_acc < 6 && n < 100) begin
      prev = accept_cnt;
      tick();
      if (accept_cnt != prev) set_random();
      n++;
    end
    in_valid = 1'b0;
    drain();
    chk("bp_pops", 512'(pop_cnt - base_pop), 512'(6));

    // Reset with two queued results and an open accumulation.
    set_uniform(1, 1, 0, Q30, 0, 0, -128, 127);
    out_ready = 1'b0;
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    repeat (3) tick();
    chk("pre_rst_valid", 512'(out_valid), 512'(1'b1));
    send(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 512'(out_valid), 512'(1'b0));
    chk("mid_rst_busy", 512'(busy), 512'(1'b0));
    chk("mid_rst_data", 512'(out_data_vec), 512'(0));
    chk("mid_rst_in_ready", 512'(in_ready), 512'(1'b1));
    exp_q.delete();
    exp_acc_q.delete();
    for (int i = 0; i < OC_PAR; i++) m_acc[i] = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_uniform(1, 1, 100, Q30, 0, 0, -128, 127);
    check_last("post_rst", 1'b0, 4, 8);

    // Random groups with random consumer stalls.
    rand_ready = 1'b1;
    for (int g = 0; g < 25; g++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        set_random();
        send((b == 0) && ($urandom_range(0, 3) != 0), b == len - 1);
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
